class_decision: RTL and testbench
=================================

# class_decision

Window controller and winner-take-all decision stage downstream of the two-neuron spike-count stage. It opens a fixed-length classification window by driving that stage's `en_t` input. It then waits for the neuron pipeline to drain and takes the per-neuron spike increments over the window from the two 3-bit potentials. It emits a class decision over a valid/ready handshake. The neuron stage's counters are never cleared between windows, so this block works on window-relative deltas, not on absolute counts.

## Interface
Parameters:
- `WINDOW_LEN`, default 64: number of cycles `en_t` is held high per window. Legal range is 1 to 1023.
- `CNT_W`, default 3: width of the incoming potentials.
- `MIN_MARGIN`, default 2: minimum winning margin. Used only when `CLASS_REJECT_EN` is defined.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: window request pulse. Sampled only in IDLE.
- `potential1_t`, in, CNT_W: free-running count from neuron 1.
- `potential2_t`, in, CNT_W: free-running count from neuron 2.
- `en_t`, out, 1: window enable to the neuron stage.
- `busy`, out, 1: high in every state except IDLE.
- `class_valid`, out, 1: a decision is available.
- `class_ready`, in, 1: the consumer accepts the decision.
- `class_id`, out, 2: 0 means neuron 1 wins, 1 means neuron 2 wins, 2 means tie or reject.
- `class_margin`, out, CNT_W: absolute difference between the two deltas.

## Operation
The FSM states are IDLE, WINDOW, SETTLE, HOLD.

- **IDLE**: when `start` is high at an edge:
  - capture `base1`/`base2` from `potential1_t`/`potential2_t`;
  - load the window counter with `WINDOW_LEN-1`;
  - go to WINDOW.
- **WINDOW**: `en_t` is high. The counter decrements every cycle. At the edge where the counter is 0, go to SETTLE and load the settle counter with 1.
- **SETTLE**: stays here for 2 cycles to cover the neuron stage's 2-register edge-detect latency, so that late spikes are counted. On the edge leaving SETTLE:
  - `d1 = potential1_t - base1` and `d2 = potential2_t - base2`, both modulo 2^CNT_W, which handles counter wrap-around;
  - `class_margin = |d1 - d2|`;
  - `class_id` is 0 if d1>d2, 1 if d2>d1, 2 if d1==d2;
  - go to HOLD.
- **HOLD**: `class_valid` is high. `class_id` and `class_margin` stay stable until the edge where `class_valid && class_ready`. After that edge the block returns to IDLE.
- `start` is ignored in every state except IDLE. There is no queuing.
- Aliasing: more than 2^CNT_W-1 spikes from one neuron in a window aliases the delta. This is a documented limitation and is not detected.
- A reset mid-operation returns to IDLE immediately and drops all state.

## Timing
- Reset values: `en_t`=0, `busy`=0, `class_valid`=0, `class_id`=0, `class_margin`=0. `base1`/`base2` and the counters also reset to 0. The state resets to IDLE.
- Let `start` be sampled at edge E0:
  - `en_t` is high from E0 to E0+WINDOW_LEN, exactly WINDOW_LEN cycles;
  - SETTLE spans E0+WINDOW_LEN to E0+WINDOW_LEN+2;
  - `class_valid` rises at E0+WINDOW_LEN+2.
- With `class_ready` held high, `class_valid` lasts exactly 1 cycle, and a new `start` is accepted 1 cycle after the handshake edge.
- `class_ready` high outside HOLD has no effect.
- All outputs are registered. No combinational path exists from any input to any output.

## Configuration
`CLASS_REJECT_EN`:
- **Defined**: a decision with `class_margin < MIN_MARGIN` reports `class_id`=2. Ties always report 2. The margin is still reported.
- **Undefined**: only exact ties report 2. `MIN_MARGIN` is unused.

## Structure
- Shared package `class_pkg` holds:
  - the FSM state enum;
  - the class code constants (`CLASS_N1`=0, `CLASS_N2`=1, `CLASS_NONE`=2);
  - the settle depth constant (2).
- One natural sub-module, `spike_delta`: a combinational modulo subtract plus compare. It takes the base and current counts for both neurons and produces `d1`, `d2`, the margin and the raw winner. It is instantiated once.

## Test plan
- Reset during WINDOW (rst pulse at cycle 10 of 64) -> `en_t`, `busy`, `class_valid` go to 0 asynchronously. The next `start` runs a full 64-cycle window.
- Counts go from base p1=2, p2=5 to final p1=6, p2=6 -> d1=4, d2=1, `class_id`=0, margin 3. `class_valid` rises at E0+66 with WINDOW_LEN=64.
- Wrap-around: counts go from base p1=6 to final p1=1 (d1=3), with p2 unchanged -> `class_id`=0, margin 3.
- Late spike: neuron 2 spikes on the last `en_t` cycle and the counts otherwise tie -> the delta includes that spike, `class_id`=1, margin 1.
- Backpressure: `class_ready` is held low for 5 cycles in HOLD -> `class_valid` and outputs stay stable, and a `start` pulse during HOLD is ignored.
- With `CLASS_REJECT_EN` and MIN_MARGIN=2, d1=3 and d2=2 -> `class_id`=2, margin 1. Without the macro the same stimulus gives `class_id`=0.

Source files
------------

// File: rtl/class_pkg.sv
// Shared definitions for the class_decision window controller and its
// spike_delta helper: FSM states, class codes and fixed depths.
package class_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WINDOW,
    ST_SETTLE,
    ST_HOLD
  } state_e;

  // Class codes reported on class_id.
  localparam logic [1:0] CLASS_N1   = 2'd0;
  localparam logic [1:0] CLASS_N2   = 2'd1;
  localparam logic [1:0] CLASS_NONE = 2'd2;

  // Cycles spent in SETTLE; covers the neuron stage's 2-register edge detect.
  localparam int SETTLE_DEPTH = 2;

  // Window counter width; holds WINDOW_LEN-1 for WINDOW_LEN up to 1023.
  localparam int WIN_CNT_W = 10;

endpackage

// File: rtl/spike_delta.sv
// Combinational window delta: modulo-subtracts the captured base counts
// from the current counts of both neurons, then compares the two deltas.
module spike_delta
  import class_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic [CNT_W-1:0] base1_i,
  input  logic [CNT_W-1:0] base2_i,
  input  logic [CNT_W-1:0] cur1_i,
  input  logic [CNT_W-1:0] cur2_i,
  output logic [CNT_W-1:0] d1_o,
  output logic [CNT_W-1:0] d2_o,
  output logic [CNT_W-1:0] margin_o,
  output logic [1:0]       winner_o
);

  logic [CNT_W-1:0] d1;
  logic [CNT_W-1:0] d2;

  // Deltas wrap modulo 2^CNT_W, which absorbs counter roll-over in the window.
  assign d1 = cur1_i - base1_i;
  assign d2 = cur2_i - base2_i;

  // Absolute difference and raw winner; equal deltas report no winner.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if/else leaves it unassigned and infers a latch.
    margin_o = '0;
    winner_o = CLASS_NONE;
    if (d1 > d2) begin
      margin_o = d1 - d2;
      winner_o = CLASS_N1;
    end else if (d2 > d1) begin
      margin_o = d2 - d1;
      winner_o = CLASS_N2;
    end
  end

  assign d1_o = d1;
  assign d2_o = d2;

endmodule

// File: rtl/class_decision.sv
// Window controller and winner-take-all decision stage. Opens a fixed
// WINDOW_LEN-cycle window on en_t, lets the neuron pipeline settle, then
// presents the window-relative class decision on a valid/ready handshake.
// Optional build macro CLASS_REJECT_EN: decisions whose margin is below
// MIN_MARGIN are reported as CLASS_NONE.
module class_decision
  import class_pkg::*;
#(
  parameter int WINDOW_LEN = 64,
  parameter int CNT_W      = 3,
  parameter int MIN_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] potential1_t,
  input  logic [CNT_W-1:0] potential2_t,
  output logic             en_t,
  output logic             busy,
  output logic             class_valid,
  input  logic             class_ready,
  output logic [1:0]       class_id,
  output logic [CNT_W-1:0] class_margin
);

`ifdef CLASS_REJECT_EN
  localparam bit REJECT_EN = 1'b1;
`else
  localparam bit REJECT_EN = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [WIN_CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [1:0]             settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]       base1_q, base1_d;
  logic [CNT_W-1:0]       base2_q, base2_d;
  logic [1:0]             class_id_q, class_id_d;
  logic [CNT_W-1:0]       class_margin_q, class_margin_d;
  logic                   en_t_q, en_t_d;
  logic                   busy_q, busy_d;
  logic                   class_valid_q, class_valid_d;

  logic [CNT_W-1:0]       d1, d2, margin;
  logic [1:0]             winner;
  logic [1:0]             decided_id;

  spike_delta #(.CNT_W(CNT_W)) u_spike_delta (
    .base1_i  (base1_q),
    .base2_i  (base2_q),
    .cur1_i   (potential1_t),
    .cur2_i   (potential2_t),
    .d1_o     (d1),
    .d2_o     (d2),
    .margin_o (margin),
    .winner_o (winner)
  );

  // The raw deltas are available for observation but the decision only
  // needs the margin and winner.
  logic unused_deltas;
  assign unused_deltas = ^{d1, d2};

  // Optional low-margin reject on top of the raw winner.
  always_comb begin
    decided_id = winner;
    if (REJECT_EN && (int'(margin) < MIN_MARGIN)) begin
      decided_id = CLASS_NONE;
    end
  end

  // Next-state and next-output logic; outputs are derived from the next
  // state so every port is driven straight from a flop.
  always_comb begin
    state_d        = state_q;
    win_cnt_d      = win_cnt_q;
    settle_cnt_d   = settle_cnt_q;
    base1_d        = base1_q;
    base2_d        = base2_q;
    class_id_d     = class_id_q;
    class_margin_d = class_margin_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base1_d   = potential1_t;
          base2_d   = potential2_t;
          win_cnt_d = WIN_CNT_W'(WINDOW_LEN - 1);
          state_d   = ST_WINDOW;
        end
      end
      ST_WINDOW: begin
        if (win_cnt_q == '0) begin
          settle_cnt_d = 2'(SETTLE_DEPTH - 1);
          state_d      = ST_SETTLE;
        end else begin
          win_cnt_d = win_cnt_q - WIN_CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          class_id_d     = decided_id;
          class_margin_d = margin;
          state_d        = ST_HOLD;
        end else begin
          settle_cnt_d = settle_cnt_q - 2'd1;
        end
      end
      ST_HOLD: begin
        if (class_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    en_t_d        = (state_d == ST_WINDOW);
    busy_d        = (state_d != ST_IDLE);
    class_valid_d = (state_d == ST_HOLD);
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register here is a plain flop (no memory array), so all of
    // them take a defined reset value; a mid-window reset drops everything.
    if (rst) begin
      state_q        <= ST_IDLE;
      win_cnt_q      <= '0;
      settle_cnt_q   <= '0;
      base1_q        <= '0;
      base2_q        <= '0;
      class_id_q     <= CLASS_N1;
      class_margin_q <= '0;
      en_t_q         <= 1'b0;
      busy_q         <= 1'b0;
      class_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q        <= state_d;
      win_cnt_q      <= win_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      base1_q        <= base1_d;
      base2_q        <= base2_d;
      class_id_q     <= class_id_d;
      class_margin_q <= class_margin_d;
      en_t_q         <= en_t_d;
      busy_q         <= busy_d;
      class_valid_q  <= class_valid_d;
    end
  end

  assign en_t         = en_t_q;
  assign busy         = busy_q;
  assign class_valid  = class_valid_q;
  assign class_id     = class_id_q;
  assign class_margin = class_margin_q;

endmodule

// File: tb/tb_class_decision.sv
// Self-checking bench for class_decision. Spikes are injected as random
// increments on the two potentials; the reference result comes from the
// number of spikes injected between start capture and the decision edge.
module tb_class_decision;

  localparam int L    = 64;
  localparam int W    = 3;
  localparam int MINM = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         class_ready;
  logic [W-1:0] p1, p2;
  logic         en_t, busy, class_valid;
  logic [1:0]   class_id;
  logic [W-1:0] class_margin;

  int n_checks = 0;
  int n_errors = 0;

  class_decision #(.WINDOW_LEN(L), .CNT_W(W), .MIN_MARGIN(MINM)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .potential1_t (p1),
    .potential2_t (p2),
    .en_t         (en_t),
    .busy         (busy),
    .class_valid  (class_valid),
    .class_ready  (class_ready),
    .class_id     (class_id),
    .class_margin (class_margin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference decision from spike totals (deltas are counts modulo 2^W).
  function automatic void model(input int n1, input int n2, output int eid, output int emar);
    int d1, d2;
    d1 = n1 % (1 << W);
    d2 = n2 % (1 << W);
    emar = (d1 > d2) ? d1 - d2 : d2 - d1;
    eid  = (d1 > d2) ? 0 : ((d2 > d1) ? 1 : 2);
`ifdef CLASS_REJECT_EN
    if (emar < MINM) eid = 2;
`endif
  endfunction

  // One full transaction. n1/n2 spikes are spread over the L+2 cycles after
  // start; late2 forces one neuron-2 spike into the very last cycle before
  // the decision. hold>0 keeps class_ready low that many cycles in HOLD.
  task automatic run_txn(input logic [W-1:0] b1, input logic [W-1:0] b2,
                         input int n1, input int n2, input bit late2,
                         input int hold, input string tag);
    bit inc1[L+2];
    bit inc2[L+2];
    int rem, lim, eid, emar, en_cnt, rise, busy_low, c;

    rem = n1;
    for (int k = 0; k < L + 2; k++) begin
      inc1[k] = (int'($urandom_range(L + 1 - k, 0)) < rem);
      if (inc1[k]) rem--;
    end
    rem = late2 ? n2 - 1 : n2;
    lim = late2 ? L + 1 : L + 2;
    for (int k = 0; k < L + 2; k++) begin
      if (k < lim) begin
        inc2[k] = (int'($urandom_range(lim - 1 - k, 0)) < rem);
        if (inc2[k]) rem--;
      end else begin
        inc2[k] = late2;
      end
    end
    model(n1, n2, eid, emar);

    class_ready = (hold == 0);
    p1 = b1;
    p2 = b2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ":en_t_on"}, en_t, 1);
    en_cnt = 1; rise = -1; busy_low = 0; c = 0;

    for (int k = 0; k < L + 2; k++) begin
      p1 = p1 + W'(inc1[k]);
      p2 = p2 + W'(inc2[k]);
      @(posedge clk); #1;
      c++;
      if (en_t) en_cnt++;
      if (!busy) busy_low++;
      if (class_valid && rise < 0) rise = c;
    end
    while (rise < 0 && c < L + 12) begin
      @(posedge clk); #1;
      c++;
      if (class_valid) rise = c;
    end

    check({tag, ":en_cycles"}, en_cnt, L);
    check({tag, ":valid_rise"}, rise, L + 2);
    check({tag, ":busy_low"}, busy_low, 0);
    check({tag, ":valid"}, class_valid, 1);
    check({tag, ":id"}, class_id, eid);
    check({tag, ":margin"}, class_margin, emar);

    for (int h = 0; h < hold; h++) begin
      start = (h == 1);
      p1 = W'($urandom);
      p2 = W'($urandom);
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, class_valid, 1);
      check({tag, ":hold_id"}, class_id, eid);
      check({tag, ":hold_margin"}, class_margin, emar);
    end
    start = 1'b0;
    class_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ":valid_drop"}, class_valid, 0);
    check({tag, ":busy_drop"}, busy, 0);
    class_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b1, b2, n1, n2, hold;
    bit late;

    rst = 1'b1; start = 1'b0; class_ready = 1'b0; p1 = '0; p2 = '0;
    #12;
    check("rst:en_t", en_t, 0);
    check("rst:busy", busy, 0);
    check("rst:valid", class_valid, 0);
    check("rst:id", class_id, 0);
    check("rst:margin", class_margin, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle:busy", busy, 0);

    run_txn(3'd2, 3'd5, 4, 1, 1'b0, 0, "basic");
    run_txn(3'd6, 3'd3, 3, 0, 1'b0, 0, "wrap");
    run_txn(3'd1, 3'd1, 3, 4, 1'b1, 0, "late");
    run_txn(3'd0, 3'd4, 3, 2, 1'b0, 5, "bp");

    // Reset in the middle of a window, away from any clock edge.
    p1 = 3'd3; p2 = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check("midrst:en_t", en_t, 0);
    check("midrst:busy", busy, 0);
    check("midrst:valid", class_valid, 0);
    check("midrst:margin", class_margin, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("midrst:idle", busy, 0);
    run_txn(3'd5, 3'd0, 2, 2, 1'b0, 0, "post_rst");

    for (int t = 0; t < 8; t++) begin
      b1   = int'($urandom_range(7, 0));
      b2   = int'($urandom_range(7, 0));
      n1   = int'($urandom_range(7, 0));
      n2   = int'($urandom_range(7, 0));
      late = 1'($urandom);
      if (late && n2 == 0) n2 = 1;
      hold = int'($urandom_range(3, 0));
      run_txn(W'(b1), W'(b2), n1, n2, late, hold, $sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
